// File: rtl/bomb_slot_sched_if.sv
// Player request / slot status bundle between the bomb scheduler
// and its neighbours (input debouncers, map/collision, VGA).
interface bomb_slot_sched_if #(
    parameter int NSLOT = 6
);
    logic               tick;
    logic               req0;
    logic               req1;
    logic [5:0]         x0;
    logic [5:0]         y0;
    logic [5:0]         x1;
    logic [5:0]         y1;
    logic               grant0;
    logic               grant1;
    logic               deny0;
    logic               deny1;
    logic [6*NSLOT-1:0] slot_x;
    logic [6*NSLOT-1:0] slot_y;
    logic [NSLOT-1:0]   busy;
    logic [NSLOT-1:0]   blast;
    logic [NSLOT-1:0]   owner;
    logic [2:0]         cnt0;
    logic [2:0]         cnt1;

    modport master (
        output tick, req0, req1, x0, y0, x1, y1,
        input  grant0, grant1, deny0, deny1,
        input  slot_x, slot_y, busy, blast, owner, cnt0, cnt1
    );

    modport slave (
        input  tick, req0, req1, x0, y0, x1, y1,
        output grant0, grant1, deny0, deny1,
        output slot_x, slot_y, busy, blast, owner, cnt0, cnt1
    );
endinterface

// File: rtl/bomb_slot_sched.sv
// Shared bomb-slot pool for two players: round-robin arbitration,
// per-player cap, unique cells, and fuse/blast sequencing per slot.
module bomb_slot_sched #(
    parameter int NSLOT      = 6,
    parameter int PER_PLAYER = 3,
    parameter int FUSE_MS    = 3000,
    parameter int BLAST_MS   = 1000,
    parameter int CW         = 13
) (
    input logic              clk,
    input logic              rst_n,
    bomb_slot_sched_if.slave bus
);
    localparam int IW = $clog2(NSLOT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_BLAST = 2'd2;

    logic [1:0]       st_q  [NSLOT];
    logic [1:0]       st_d  [NSLOT];
    logic [CW-1:0]    ct_q  [NSLOT];
    logic [CW-1:0]    ct_d  [NSLOT];
    logic [5:0]       x_q   [NSLOT];
    logic [5:0]       x_d   [NSLOT];
    logic [5:0]       y_q   [NSLOT];
    logic [5:0]       y_d   [NSLOT];
    logic [NSLOT-1:0] own_q;
    logic [NSLOT-1:0] own_d;

    logic       rr_q;
    logic       rr_d;
    logic [2:0] cnt0_q;
    logic [2:0] cnt1_q;
    logic [2:0] cnt0_d;
    logic [2:0] cnt1_d;
    logic       g0_q;
    logic       g1_q;
    logic       d0_q;
    logic       d1_q;

    logic          dup0;
    logic          dup1;
    logic          ok0;
    logic          ok1;
    logic          contest;
    logic          g0;
    logic          g1;
    logic          f1_ok;
    logic          f2_ok;
    logic [IW-1:0] f1;
    logic [IW-1:0] f2;
    logic [IW-1:0] s0;
    logic [IW-1:0] s1;

    // Decisions use registered state only; a slot retiring this cycle
    // still counts as busy and still owns its cell.
    always_comb begin : eval
        dup0  = 1'b0;
        dup1  = 1'b0;
        f1_ok = 1'b0;
        f2_ok = 1'b0;
        f1    = '0;
        f2    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (st_q[i] != ST_IDLE) begin
                if (x_q[i] == bus.x0 && y_q[i] == bus.y0) dup0 = 1'b1;
                if (x_q[i] == bus.x1 && y_q[i] == bus.y1) dup1 = 1'b1;
            end else if (!f1_ok) begin
                f1_ok = 1'b1;
                f1    = IW'(i);
            end else if (!f2_ok) begin
                f2_ok = 1'b1;
                f2    = IW'(i);
            end
        end
        ok0 = bus.req0 && (cnt0_q < 3'(PER_PLAYER)) && !dup0 && f1_ok;
        ok1 = bus.req1 && (cnt1_q < 3'(PER_PLAYER)) && !dup1 && f1_ok;
        contest = ok0 && ok1 &&
                  ((bus.x0 == bus.x1 && bus.y0 == bus.y1) || !f2_ok);
        g0   = ok0 && !(contest && rr_q);
        g1   = ok1 && !(contest && !rr_q);
        s0   = (g1 && rr_q) ? f2 : f1;
        s1   = (g0 && !rr_q) ? f2 : f1;
        rr_d = contest ? !rr_q : rr_q;
    end

    always_comb begin : next
        cnt0_d = '0;
        cnt1_d = '0;
        own_d  = own_q;
        for (int i = 0; i < NSLOT; i++) begin
            st_d[i] = st_q[i];
            ct_d[i] = ct_q[i];
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            case (st_q[i])
                ST_IDLE: begin
                    if (g0 && s0 == IW'(i)) begin
                        st_d[i]  = ST_ARMED;
                        ct_d[i]  = CW'(FUSE_MS);
                        x_d[i]   = bus.x0;
                        y_d[i]   = bus.y0;
                        own_d[i] = 1'b0;
                    end else if (g1 && s1 == IW'(i)) begin
                        st_d[i]  = ST_ARMED;
                        ct_d[i]  = CW'(FUSE_MS);
                        x_d[i]   = bus.x1;
                        y_d[i]   = bus.y1;
                        own_d[i] = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bus.tick) begin
                        if (ct_q[i] == CW'(1)) begin
                            st_d[i] = ST_BLAST;
                            ct_d[i] = CW'(BLAST_MS);
                        end else begin
                            ct_d[i] = ct_q[i] - CW'(1);
                        end
                    end
                end
                ST_BLAST: begin
                    if (bus.tick) begin
                        if (ct_q[i] == CW'(1)) begin
                            st_d[i]  = ST_IDLE;
                            ct_d[i]  = '0;
                            x_d[i]   = '0;
                            y_d[i]   = '0;
                            own_d[i] = 1'b0;
                        end else begin
                            ct_d[i] = ct_q[i] - CW'(1);
                        end
                    end
                end
                default: begin
                    st_d[i]  = ST_IDLE;
                    ct_d[i]  = '0;
                    x_d[i]   = '0;
                    y_d[i]   = '0;
                    own_d[i] = 1'b0;
                end
            endcase
            if (st_d[i] != ST_IDLE) begin
                if (own_d[i]) cnt1_d = cnt1_d + 3'd1;
                else          cnt0_d = cnt0_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                st_q[i] <= ST_IDLE;
                ct_q[i] <= '0;
                x_q[i]  <= '0;
                y_q[i]  <= '0;
            end
            own_q  <= '0;
            rr_q   <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
            g0_q   <= 1'b0;
            g1_q   <= 1'b0;
            d0_q   <= 1'b0;
            d1_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                st_q[i] <= st_d[i];
                ct_q[i] <= ct_d[i];
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
            end
            own_q  <= own_d;
            rr_q   <= rr_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            g0_q   <= g0;
            g1_q   <= g1;
            d0_q   <= bus.req0 && !g0;
            d1_q   <= bus.req1 && !g1;
        end
    end

    always_comb begin : drive
        bus.slot_x = '0;
        bus.slot_y = '0;
        bus.busy   = '0;
        bus.blast  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            bus.slot_x[6*i +: 6] = x_q[i];
            bus.slot_y[6*i +: 6] = y_q[i];
            bus.busy[i]          = st_q[i] != ST_IDLE;
            bus.blast[i]         = st_q[i] == ST_BLAST;
        end
    end

    assign bus.owner  = own_q;
    assign bus.cnt0   = cnt0_q;
    assign bus.cnt1   = cnt1_q;
    assign bus.grant0 = g0_q;
    assign bus.grant1 = g1_q;
    assign bus.deny0  = d0_q;
    assign bus.deny1  = d1_q;
endmodule

// File: tb/tb_bomb_slot_sched.sv
// Bench for bomb_slot_sched: slot-age reference model checked every
// cycle, plus directed literal expectations.
module tb_bomb_slot_sched;
    localparam int NS    = 6;
    localparam int PP    = 3;
    localparam int FUSE  = 3000;
    localparam int BLAST = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bomb_slot_sched_if #(.NSLOT(NS)) bus ();

    bomb_slot_sched #(
        .NSLOT(NS), .PER_PLAYER(PP), .FUSE_MS(FUSE),
        .BLAST_MS(BLAST), .CW(13)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: each slot remembers how many ticks it has lived.
    bit         m_used [NS];
    int         m_age  [NS];
    logic [5:0] m_x    [NS];
    logic [5:0] m_y    [NS];
    bit         m_own  [NS];
    bit         m_rr;
    bit         e_g0, e_g1, e_d0, e_d1;
    bit         started = 1'b0;
    int         freeq[$];

    always @(posedge clk) begin : model
        int c0, c1, s0, s1;
        bit dup0, dup1, ok0, ok1, w0, w1;
        started = 1'b1;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                m_used[i] = 0; m_age[i] = 0;
                m_x[i] = '0; m_y[i] = '0; m_own[i] = 0;
            end
            m_rr = 0;
            e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0;
        end else begin
            c0 = 0; c1 = 0; dup0 = 0; dup1 = 0;
            freeq.delete();
            for (int i = 0; i < NS; i++) begin
                if (m_used[i]) begin
                    if (m_own[i]) c1++; else c0++;
                    if (m_x[i] == bus.x0 && m_y[i] == bus.y0) dup0 = 1;
                    if (m_x[i] == bus.x1 && m_y[i] == bus.y1) dup1 = 1;
                end else begin
                    freeq.push_back(i);
                end
            end
            ok0 = bus.req0 && c0 < PP && !dup0 && freeq.size() > 0;
            ok1 = bus.req1 && c1 < PP && !dup1 && freeq.size() > 0;
            w0 = ok0; w1 = ok1; s0 = 0; s1 = 0;
            if (ok0 && ok1 &&
                ((bus.x0 == bus.x1 && bus.y0 == bus.y1) || freeq.size() < 2)) begin
                w0 = !m_rr; w1 = m_rr; m_rr = !m_rr;
                s0 = freeq[0]; s1 = freeq[0];
            end else if (ok0 && ok1) begin
                s0 = m_rr ? freeq[1] : freeq[0];
                s1 = m_rr ? freeq[0] : freeq[1];
            end else if (ok0 || ok1) begin
                s0 = freeq[0]; s1 = freeq[0];
            end
            for (int i = 0; i < NS; i++) begin
                if (m_used[i] && bus.tick) begin
                    m_age[i]++;
                    if (m_age[i] == FUSE + BLAST) begin
                        m_used[i] = 0; m_x[i] = '0; m_y[i] = '0;
                    end
                end
            end
            if (w0) begin
                m_used[s0] = 1; m_age[s0] = 0; m_own[s0] = 0;
                m_x[s0] = bus.x0; m_y[s0] = bus.y0;
            end
            if (w1) begin
                m_used[s1] = 1; m_age[s1] = 0; m_own[s1] = 1;
                m_x[s1] = bus.x1; m_y[s1] = bus.y1;
            end
            e_g0 = w0; e_g1 = w1;
            e_d0 = bus.req0 && !w0;
            e_d1 = bus.req1 && !w1;
        end
    end

    always @(negedge clk) begin : compare
        logic [NS-1:0]   eb, ebl, eo;
        logic [6*NS-1:0] ex, ey;
        logic [2:0]      ec0, ec1;
        if (started) begin
            eb = '0; ebl = '0; eo = '0; ex = '0; ey = '0;
            ec0 = '0; ec1 = '0;
            for (int i = 0; i < NS; i++) begin
                if (m_used[i]) begin
                    eb[i]  = 1'b1;
                    ebl[i] = m_age[i] >= FUSE;
                    eo[i]  = m_own[i];
                    ex[6*i +: 6] = m_x[i];
                    ey[6*i +: 6] = m_y[i];
                    if (m_own[i]) ec1 = ec1 + 3'd1;
                    else          ec0 = ec0 + 3'd1;
                end
            end
            chk("grant0", bus.grant0, e_g0);
            chk("grant1", bus.grant1, e_g1);
            chk("deny0", bus.deny0, e_d0);
            chk("deny1", bus.deny1, e_d1);
            chk("busy", bus.busy, eb);
            chk("blast", bus.blast, ebl);
            chk("owner", bus.owner & bus.busy, eo);
            chk("slot_x", bus.slot_x, ex);
            chk("slot_y", bus.slot_y, ey);
            chk("cnt0", bus.cnt0, ec0);
            chk("cnt1", bus.cnt1, ec1);
        end
    end

    task automatic step(input bit t, input bit r0, input bit r1);
        bus.tick = t; bus.req0 = r0; bus.req1 = r1;
        @(negedge clk);
        bus.tick = 0; bus.req0 = 0; bus.req1 = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0);
    endtask

    task automatic cell0(input int x, input int y);
        bus.x0 = 6'(x); bus.y0 = 6'(y);
    endtask

    task automatic cell1(input int x, input int y);
        bus.x1 = 6'(x); bus.y1 = 6'(y);
    endtask

    initial begin
        bus.tick = 0; bus.req0 = 0; bus.req1 = 0;
        cell0(0, 0); cell1(0, 0);
        rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_busy", bus.busy, 6'd0);
        chk("rst_cnt0", bus.cnt0, 3'd0);
        chk("rst_grant0", bus.grant0, 1'b0);
        chk("rst_slot_x", bus.slot_x, 36'd0);
        rst_n = 1'b1;

        // single bomb, tick in the grant cycle must not count
        cell0(3, 4);
        step(1, 1, 0);
        chk("t1_grant0", bus.grant0, 1'b1);
        chk("t1_busy", bus.busy, 6'b000001);
        chk("t1_owner", bus.owner, 6'b000000);
        chk("t1_x", bus.slot_x, 36'd3);
        chk("t1_y", bus.slot_y, 36'd4);
        ticks(FUSE - 1);
        chk("t1_fuse_end", bus.blast, 6'b000000);
        ticks(1);
        chk("t1_blast", bus.blast, 6'b000001);
        ticks(BLAST - 1);
        chk("t1_blast_end", bus.busy, 6'b000001);
        ticks(1);
        chk("t1_idle", bus.busy, 6'b000000);

        // per-player cap, then duplicate cell
        cell0(1, 1); step(0, 1, 0);
        cell0(2, 1); step(0, 1, 0);
        cell0(3, 1); step(0, 1, 0);
        cell0(4, 1); step(0, 1, 0);
        chk("t2_deny0", bus.deny0, 1'b1);
        chk("t2_cnt0", bus.cnt0, 3'd3);
        chk("t2_busy", bus.busy, 6'b000111);
        cell1(1, 1); step(0, 0, 1);
        chk("t2_dup_deny1", bus.deny1, 1'b1);
        ticks(FUSE + BLAST);
        chk("t2_clear", bus.busy, 6'b000000);

        // contested same cell, twice
        cell0(5, 5); cell1(5, 5); step(0, 1, 1);
        chk("t3_grant0", bus.grant0, 1'b1);
        chk("t3_deny1", bus.deny1, 1'b1);
        ticks(FUSE + BLAST);
        step(0, 1, 1);
        chk("t3_grant1", bus.grant1, 1'b1);
        chk("t3_deny0", bus.deny0, 1'b1);
        chk("t3_owner", bus.owner, 6'b000001);
        ticks(FUSE + BLAST);

        // both fit: priority p0 gets slot 0, p1 slot 1
        cell0(7, 7); cell1(8, 8); step(0, 1, 1);
        chk("t3_both_busy", bus.busy, 6'b000011);
        chk("t3_both_owner", bus.owner, 6'b000010);

        // full pool; slot 2 retires alone while req1 arrives
        ticks(10);
        cell1(9, 9); step(0, 0, 1);
        ticks(FUSE + BLAST - 10);
        chk("t4_only2", bus.busy, 6'b000100);
        cell0(10, 10); step(0, 1, 0);
        cell0(11, 11); step(0, 1, 0);
        cell0(12, 12); step(0, 1, 0);
        cell1(13, 13); step(0, 0, 1);
        cell1(14, 14); step(0, 0, 1);
        chk("t4_full", bus.busy, 6'b111111);
        chk("t4_cnt1", bus.cnt1, 3'd3);
        ticks(9);
        cell1(15, 15); step(1, 0, 1);
        chk("t4_deny1", bus.deny1, 1'b1);
        chk("t4_freed", bus.busy, 6'b111011);
        step(0, 0, 1);
        chk("t4_grant1", bus.grant1, 1'b1);
        chk("t4_refill", bus.busy, 6'b111111);
        chk("t4_owner", bus.owner, 6'b110100);
        ticks(FUSE + BLAST);
        chk("t4_clear", bus.busy, 6'b000000);

        // reset mid-fuse aborts the bomb
        cell0(20, 20); step(0, 1, 0);
        ticks(1500);
        rst_n = 1'b0;
        step(0, 0, 0);
        chk("t5_busy", bus.busy, 6'b000000);
        chk("t5_blast", bus.blast, 6'b000000);
        chk("t5_cnt0", bus.cnt0, 3'd0);
        chk("t5_cnt1", bus.cnt1, 3'd0);
        rst_n = 1'b1;
        ticks(FUSE);
        chk("t5_no_blast", bus.blast, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
